// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadow digit registers,
// leading-zero blanking and an anode-off guard interval between digits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 8,
  parameter int HEX_ENABLE   = 0,
  parameter int BLANK_LZ     = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic [4*NUM_DIGITS-1:0] i_DIGITS,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic                    i_LOAD,
  output logic [6:0]              o_SEG,
  output logic                    o_DP,
  output logic [NUM_DIGITS-1:0]   o_AN,
  output logic                    o_SCAN_TICK
);

  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [TW-1:0] DRIVE_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  typedef enum logic {ST_GUARD, ST_DRIVE} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           index_q, index_d;
  logic                    wrap_q, wrap_d;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              active_digit;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = 7'h77;
      4'd11:   s = 7'h7C;
      4'd12:   s = 7'h39;
      4'd13:   s = 7'h5E;
      4'd14:   s = 7'h79;
      default: s = 7'h71;
    endcase
    if (HEX_ENABLE == 0 && v > 4'd9) s = 7'h00;
    return s;
  endfunction

  // State register: every flop, including the shadow digits, is cleared by reset.
  always_ff @(posedge i_CLK) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (!i_RST_N) begin
      state_q         <= ST_GUARD;
      timer_q         <= '0;
      index_q         <= '0;
      wrap_q          <= 1'b0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      seg_q           <= {7{POL}};
      dp_q            <= POL;
      an_q            <= {NUM_DIGITS{POL}};
      tick_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      index_q         <= index_d;
      wrap_q          <= wrap_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      an_q            <= an_d;
      tick_q          <= tick_d;
    end
  end

  // Next-state: wrap_d marks the FSM cycle in which the index returns to 0.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d         = state_q;
    timer_d         = timer_q + 1'b1;
    index_d         = index_q;
    wrap_d          = 1'b0;
    shadow_digits_d = i_LOAD ? i_DIGITS : shadow_digits_q;
    shadow_dp_d     = i_LOAD ? i_DP : shadow_dp_q;
    case (state_q)
      ST_GUARD: begin
        if (GUARD_CYCLES == 0 || timer_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          timer_d = '0;
        end
      end
      default: begin
        if (timer_q == DRIVE_LAST) begin
          state_d = (GUARD_CYCLES == 0) ? ST_DRIVE : ST_GUARD;
          timer_d = '0;
          index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
          wrap_d  = (index_q == LAST_IDX);
        end
      end
    endcase
  end

  // Output decode, registered one cycle behind the FSM.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow_digits_q[4*k +: 4] == 4'd0) && !shadow_dp_q[k];
      blank[k] = zero_run && (BLANK_LZ != 0);
    end

    active_digit = shadow_digits_q[{index_q, 2'b00} +: 4];
    seg_raw      = '0;
    an_raw       = '0;
    dp_d         = POL;
    if (state_q == ST_DRIVE) begin
      seg_raw         = blank[index_q] ? 7'h00 : decode(active_digit);
      an_raw[index_q] = 1'b1;
      dp_d            = shadow_dp_q[index_q] ^ POL;
    end
    seg_d  = seg_raw ^ {7{POL}};
    an_d   = an_raw ^ {NUM_DIGITS{POL}};
    tick_d = wrap_q;
  end

  assign o_SEG       = seg_q;
  assign o_DP        = dp_q;
  assign o_AN        = an_q;
  assign o_SCAN_TICK = tick_q;

endmodule
